// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//  - ADDR_W, IMEM_WORDS, RESET_PC, BUF_DEPTH : fetch geometry
//  - fetch_state_e : fetch FSM state encoding
//  - fetch_entry_t : one buffered fetch {instr, pc}
//  - pc_legal      : aligned and inside the instruction memory
package riscv_pkg;

    localparam int              ADDR_W     = 11;
    localparam int              IMEM_WORDS = 34;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam int              BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic pc_legal(input logic [ADDR_W-1:0] pc, input int words);
        return (pc[1:0] == 2'b00) && (32'(pc[ADDR_W-1:2]) < 32'(words));
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer between the PC/imem read and decode.
// Ports:
//  clk_i, rst_i  : clock, asynchronous active-high reset
//  push_i/data_i : write one fetch entry (caller guarantees room or same-cycle pop)
//  pop_i         : remove the head entry
//  flush_i       : discard all entries; overrides push and pop
//  head_o        : entry at the head (valid only when valid_o)
//  valid_o       : at least one entry buffered
//  count_o       : number of buffered entries (0..2)
module fetch_skid_fifo
    import riscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [BUF_DEPTH];
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            count_d = 2'd0;
        end else begin
            rd_d    = rd_q ^ pop_i;
            wr_d    = wr_q ^ push_i;
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i && !flush_i) begin
                mem_q[wr_q] <= data_i;
            end
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory,
// buffers fetched words in a 2-entry skid FIFO and hands them to decode.
// Ports:
//  clk, rst            : clock, asynchronous active-high reset
//  en                  : fetch enable
//  imem_addr/imem_instr: byte address out (= PC), combinational read data in
//  if_valid/if_instr/if_pc/if_pc_plus4 : FIFO head towards decode
//  id_ready            : decode accepts the head this cycle
//  redirect_valid/pc   : taken branch/jump target
//  fault/fault_pc      : sticky fetch fault and the offending PC
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [riscv_pkg::ADDR_W-1:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int                           IMEM_WORDS = riscv_pkg::IMEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

    logic              push, pop, flush;
    logic              fifo_valid;
    logic [1:0]        fifo_count;
    fetch_entry_t      head;
    fetch_entry_t      new_entry;
    logic              pc_ok, tgt_ok;

    assign pc_ok     = pc_legal(pc_q, IMEM_WORDS);
    assign tgt_ok    = pc_legal(redirect_pc, IMEM_WORDS);
    assign pop       = fifo_valid & id_ready;
    assign new_entry = '{instr: imem_instr, pc: pc_q};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                    if (!en) state_d = ST_IDLE;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end else if (!pc_ok) begin
                    // The illegal PC itself is never pushed; older entries keep draining.
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end else if ((fifo_count != 2'(BUF_DEPTH)) || pop) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                    if (tgt_ok) begin
                        state_d = ST_FETCH;
                        fault_d = 1'b0;
                    end else begin
                        fault_pc_d = redirect_pc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (new_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = fifo_valid;
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + ADDR_W'(4);
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [10:0] if_pc;
    logic [10:0] if_pc_plus4;
    logic        id_ready;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic        fault;
    logic [10:0] fault_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [34] = '{
        32'hfe010113, 32'h00812e23, 32'h02010413, 32'hfe042623, 32'hfe042423, 32'h0200006f,
        32'hfec42783, 32'h00178793, 32'hfef42623, 32'hfe842783, 32'h00178793, 32'hfef42423,
        32'hfe842783, 32'h00900713, 32'hfcf75ee3, 32'hfe842703, 32'h00070793, 32'h00078513,
        32'h01c12403, 32'h02010113, 32'h00000013, 32'h00000013, 32'h00100093, 32'h00200113,
        32'h002081b3, 32'h40208233, 32'h0020f2b3, 32'h0020e333, 32'h0020c3b3, 32'h00209433,
        32'h0020d4b3, 32'h00000013, 32'h00000013, 32'h00008067
    };

    function automatic logic [31:0] prog_at(input logic [10:0] a);
        if (int'(a[10:2]) < 34) return prog[int'(a[10:2])];
        return 32'h0;
    endfunction

    assign imem_instr = prog_at(imem_addr);

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        rv;
        logic [10:0] rpc;
        logic [10:0] addr;
        logic        v;
        logic [10:0] pc;
        logic        f;
        logic [10:0] fpc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic rd, input logic rv,
                                input logic [10:0] rpc, input logic [10:0] addr, input logic v,
                                input logic [10:0] pc, input logic f, input logic [10:0] fpc);
        vec_t t;
        t.rst = r;  t.en = e;  t.rdy = rd; t.rv = rv; t.rpc = rpc;
        t.addr = addr; t.v = v; t.pc = pc; t.f = f; t.fpc = fpc;
        return t;
    endfunction

    vec_t tbl [25];

    initial begin
        logic [10:0] last_pc;
        logic        fault_seen;
        logic [10:0] exp_pc;
        logic        prev_redir;
        logic        rdy_n, rv_n;
        logic [10:0] tgt;
        int          accepts;

        // reset / first fetches
        tbl[0]  = mk(1,0,0,0,11'h000, 11'h000,0,11'h000,0,11'h000);
        tbl[1]  = mk(0,1,1,0,11'h000, 11'h000,0,11'h000,0,11'h000);
        tbl[2]  = mk(0,1,1,0,11'h000, 11'h004,1,11'h000,0,11'h000);
        tbl[3]  = mk(0,1,1,0,11'h000, 11'h008,1,11'h004,0,11'h000);
        tbl[4]  = mk(0,1,1,0,11'h000, 11'h00C,1,11'h008,0,11'h000);
        // backpressure
        tbl[5]  = mk(1,0,0,0,11'h000, 11'h000,0,11'h000,0,11'h000);
        tbl[6]  = mk(0,1,0,0,11'h000, 11'h000,0,11'h000,0,11'h000);
        tbl[7]  = mk(0,1,0,0,11'h000, 11'h004,1,11'h000,0,11'h000);
        for (int i = 8; i <= 12; i++)
            tbl[i] = mk(0,1,0,0,11'h000, 11'h008,1,11'h000,0,11'h000);
        tbl[13] = mk(0,1,1,0,11'h000, 11'h00C,1,11'h004,0,11'h000);
        tbl[14] = mk(0,1,1,0,11'h000, 11'h010,1,11'h008,0,11'h000);
        tbl[15] = mk(0,1,1,0,11'h000, 11'h014,1,11'h00C,0,11'h000);
        // redirect while streaming
        tbl[16] = mk(0,1,1,1,11'h030, 11'h030,0,11'h000,0,11'h000);
        tbl[17] = mk(0,1,1,0,11'h000, 11'h034,1,11'h030,0,11'h000);
        tbl[18] = mk(0,1,1,0,11'h000, 11'h038,1,11'h034,0,11'h000);
        // misaligned redirect, then legal redirect out of fault
        tbl[19] = mk(0,1,1,1,11'h032, 11'h032,0,11'h000,0,11'h000);
        tbl[20] = mk(0,1,1,0,11'h000, 11'h032,0,11'h000,1,11'h032);
        tbl[21] = mk(0,1,1,0,11'h000, 11'h032,0,11'h000,1,11'h032);
        tbl[22] = mk(0,1,1,1,11'h03C, 11'h03C,0,11'h000,0,11'h000);
        tbl[23] = mk(0,1,1,0,11'h000, 11'h040,1,11'h03C,0,11'h000);
        tbl[24] = mk(0,1,1,0,11'h000, 11'h044,1,11'h040,0,11'h000);

        rst = 1'b1; en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; id_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            @(negedge clk);
            check($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            check($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(tbl[i].v));
            check($sformatf("row%0d fault", i), 32'(fault), 32'(tbl[i].f));
            if (tbl[i].v) begin
                check($sformatf("row%0d if_pc", i), 32'(if_pc), 32'(tbl[i].pc));
                check($sformatf("row%0d if_instr", i), if_instr, prog_at(tbl[i].pc));
                check($sformatf("row%0d if_pc_plus4", i), 32'(if_pc_plus4), 32'(tbl[i].pc + 11'd4));
            end
            if (tbl[i].f) check($sformatf("row%0d fault_pc", i), 32'(fault_pc), 32'(tbl[i].fpc));
            if (tbl[i].rst) begin
                check($sformatf("row%0d rst if_instr", i), if_instr, 32'h0);
                check($sformatf("row%0d rst if_pc", i), 32'(if_pc), 32'h0);
                check($sformatf("row%0d rst fault_pc", i), 32'(fault_pc), 32'h0);
            end
        end

        // run past the end of the program
        rst = 1'b0; en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 11'h078;
        @(negedge clk);
        redirect_valid = 1'b0;
        last_pc = '0; fault_seen = 1'b0;
        for (int c = 0; c < 40 && !fault_seen; c++) begin
            @(negedge clk);
            if (fault) fault_seen = 1'b1;
            else if (if_valid) begin
                check("end_range if_pc", 32'(if_pc < 11'h088), 32'h1);
                last_pc = if_pc;
            end
        end
        check("end fault reached", 32'(fault_seen), 32'h1);
        check("end last if_pc", 32'(last_pc), 32'h084);
        check("end fault_pc", 32'(fault_pc), 32'h088);
        for (int c = 0; c < 3; c++) begin
            check("end no valid after fault", 32'(if_valid), 32'h0);
            @(negedge clk);
        end
        redirect_valid = 1'b1; redirect_pc = 11'h000;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("resume fault cleared", 32'(fault), 32'h0);
        check("resume flush", 32'(if_valid), 32'h0);
        @(negedge clk);
        check("resume if_valid", 32'(if_valid), 32'h1);
        check("resume if_pc", 32'(if_pc), 32'h000);
        check("resume if_instr", if_instr, 32'hfe010113);

        // fill the FIFO, fault behind it, then reset asynchronously
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 11'h080;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-rst if_valid", 32'(if_valid), 32'h1);
        check("pre-rst if_pc", 32'(if_pc), 32'h080);
        check("pre-rst fault", 32'(fault), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst if_valid", 32'(if_valid), 32'h0);
        check("async rst imem_addr", 32'(imem_addr), 32'h000);
        check("async rst fault", 32'(fault), 32'h0);
        check("async rst fault_pc", 32'(fault_pc), 32'h000);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; id_ready = 1'b1;

        // random stream against the in-order delivery model
        exp_pc = 11'h000; prev_redir = 1'b0; accepts = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (prev_redir) check("rand flush", 32'(if_valid), 32'h0);
            if (if_valid) begin
                check("rand pc in range", 32'(if_pc[1:0] == 2'b00 && if_pc < 11'h088), 32'h1);
                check("rand if_instr", if_instr, prog_at(if_pc));
                check("rand if_pc_plus4", 32'(if_pc_plus4), 32'(if_pc + 11'd4));
            end
            rdy_n = ($urandom_range(0, 3) != 0);
            rv_n  = (c > 3) && ($urandom_range(0, 15) == 0);
            if (fault) begin
                check("rand fault_pc", 32'(fault_pc), 32'h088);
                rv_n = 1'b1;
            end
            tgt = 11'($urandom_range(0, 33) * 4);
            if (if_valid && rdy_n) begin
                check("rand order if_pc", 32'(if_pc), 32'(exp_pc));
                exp_pc = if_pc + 11'd4;
                accepts++;
            end
            if (rv_n) exp_pc = tgt;
            id_ready = rdy_n; redirect_valid = rv_n; redirect_pc = tgt;
            prev_redir = rv_n;
        end
        check("rand throughput", 32'(accepts > 1000), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
